// File: rtl/pipe_skid_stage.sv
// Two-entry elastic pipeline register (main + skid) with valid/ready handshake.
// Upstream ready and downstream valid are pure decodes of registered state, so
// no combinational handshake path crosses the stage boundary.
module pipe_skid_stage #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready,
    output logic [1:0]            o_count
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;

    logic in_xfer;
    logic out_xfer;

    // Handshake outputs decoded from registered state only.
    always_comb begin
        o_valid = 1'b0;
        o_ready = 1'b1;
        o_count = 2'd0;
        unique case (state_q)
            StEmpty: begin
                o_valid = 1'b0;
                o_ready = 1'b1;
                o_count = 2'd0;
            end
            StBusy: begin
                o_valid = 1'b1;
                o_ready = 1'b1;
                o_count = 2'd1;
            end
            StFull: begin
                o_valid = 1'b1;
                o_ready = 1'b0;
                o_count = 2'd2;
            end
            default: begin
                o_valid = 1'b0;
                o_ready = 1'b1;
                o_count = 2'd0;
            end
        endcase
        o_data = main_q;
    end

    assign in_xfer  = i_valid && o_ready;
    assign out_xfer = o_valid && i_ready;

    // Next-state: flush empties the stage but leaves the data registers alone.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (i_flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        main_d  = i_data;
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    if (in_xfer && out_xfer) begin
                        main_d = i_data;
                    end else if (in_xfer) begin
                        skid_d  = i_data;
                        state_d = StFull;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        state_d = StBusy;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    // State and payload registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
